pe_sched_ctrl: RTL and testbench

PE_SCHED_CTRL -- requirements
Module: pe_sched_ctrl

---
 rtl/pe_ctrl_pkg.sv | 13 +
 rtl/pe_row_decode.sv | 31 +++
 rtl/pe_sched_ctrl.sv | 155 +++++++++++++++
 tb/tb_pe_sched_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_ctrl_pkg.sv
// pe_ctrl_pkg: shared states, abs_control encodings and row constants for the PE scheduler.
package pe_ctrl_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_DS, ST_FS, ST_DONE} state_t;
    localparam logic [1:0] ABS_SB0      = 2'd0;
    localparam logic [1:0] ABS_SB1      = 2'd1;
    localparam logic [1:0] ABS_SB2      = 2'd2;
    localparam logic [1:0] ABS_SB3      = 2'd3;
    localparam int         DS_HEAD_ROWS = 8;
    localparam int         DS_TAIL_ROWS = 4;
    localparam int         DS_MIN_ROWS  = 13;
    localparam int         FS_MIN_ROWS  = 5;
    localparam int         FS_REF_ROWS  = 4;
endpackage

// File: rtl/pe_row_decode.sv
// pe_row_decode: maps (mode, pass, row, rows_cfg) to the per-row PE array controls.
module pe_row_decode
    import pe_ctrl_pkg::*;
#(
    parameter int ROW_W = 7
) (
    input  logic             i_fs,
    input  logic [1:0]       i_pass,
    input  logic [ROW_W-1:0] i_row,
    input  logic [ROW_W-1:0] i_rows_cfg,
    output logic [1:0]       o_abs_control,
    output logic             o_change_ref,
    output logic             o_ref_input_control,
    output logic             o_cb_select
);
    logic w_head;
    logic w_tail;
    logic w_plus;

    always_comb begin
        w_head              = i_row < ROW_W'(DS_HEAD_ROWS);
        w_tail              = i_row >= i_rows_cfg - ROW_W'(DS_TAIL_ROWS);
        // body rows alternate between accumulators; tail rows always use base+1
        w_plus              = !w_head && (w_tail || !i_row[0]);
        o_abs_control       = i_fs ? i_pass :
                              i_pass[0] ? (w_plus ? ABS_SB3 : ABS_SB2) : (w_plus ? ABS_SB1 : ABS_SB0);
        o_change_ref        = i_fs || !w_plus || w_tail;
        o_ref_input_control = !i_fs || (i_row < ROW_W'(FS_REF_ROWS));
        o_cb_select         = !i_fs && !i_pass[0];
    end
endmodule

// File: rtl/pe_sched_ctrl.sv
// pe_sched_ctrl: per start, preloads the current block then schedules NUM_COLS search columns,
// each as two downsampled or four full-sample row passes; all outputs are registered.
module pe_sched_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int PRE_CYCLES = 64,
    parameter int NUM_COLS   = 31,
    parameter int COL_W      = 5,
    parameter int ROW_W      = 7
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_stall,
    input  logic [ROW_W-1:0] i_cfg_ds_rows,
    input  logic [ROW_W-1:0] i_cfg_fs_rows,
    input  logic [COL_W-1:0] i_cfg_fs_col_lo,
    input  logic [COL_W-1:0] i_cfg_fs_col_hi,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_row_valid,
    output logic             o_in_curr_enable,
    output logic             o_cb_select,
    output logic             o_change_ref,
    output logic             o_ref_input_control,
    output logic [1:0]       o_abs_control,
    output logic [COL_W-1:0] o_search_column_count,
    output logic [ROW_W-1:0] o_search_row_count
);
    localparam int PRE_W = $clog2(PRE_CYCLES + 1);

    state_t           r_state;
    state_t           w_state_n;
    logic [PRE_W-1:0] r_pre;
    logic [PRE_W-1:0] w_pre_n;
    logic [COL_W-1:0] r_col;
    logic [COL_W-1:0] w_col_n;
    logic [COL_W-1:0] w_col_inc;
    logic [COL_W-1:0] r_col_lo;
    logic [COL_W-1:0] r_col_hi;
    logic [1:0]       r_pass;
    logic [1:0]       w_pass_n;
    logic [ROW_W-1:0] r_row;
    logic [ROW_W-1:0] w_row_n;
    logic [ROW_W-1:0] r_ds_rows;
    logic [ROW_W-1:0] r_fs_rows;
    logic             w_fs_cur;
    logic             w_fs_nxt;
    logic             w_in_row;
    logic             w_last_row;
    logic             w_last_pass;
    logic             w_last_col;
    logic [1:0]       w_dec_abs;
    logic             w_dec_cr;
    logic             w_dec_ric;
    logic             w_dec_cb;

    pe_row_decode #(.ROW_W(ROW_W)) u_dec (
        .i_fs               (r_state == ST_FS),
        .i_pass             (r_pass),
        .i_row              (r_row),
        .i_rows_cfg         (r_ds_rows),
        .o_abs_control      (w_dec_abs),
        .o_change_ref       (w_dec_cr),
        .o_ref_input_control(w_dec_ric),
        .o_cb_select        (w_dec_cb)
    );

    always_comb begin
        w_col_inc   = r_col + COL_W'(1);
        w_fs_cur    = (r_col >= r_col_lo) && (r_col <= r_col_hi);
        w_fs_nxt    = (w_col_inc >= r_col_lo) && (w_col_inc <= r_col_hi);
        w_in_row    = (r_state == ST_DS) || (r_state == ST_FS);
        w_last_row  = r_row == ((r_state == ST_FS) ? r_fs_rows : r_ds_rows) - ROW_W'(1);
        w_last_pass = r_pass == ((r_state == ST_FS) ? 2'd3 : 2'd1);
        w_last_col  = r_col == COL_W'(NUM_COLS - 1);
        w_state_n   = r_state;
        w_pre_n     = r_pre;
        w_col_n     = r_col;
        w_pass_n    = r_pass;
        w_row_n     = r_row;
        case (r_state)
            ST_IDLE: if (i_start) begin
                w_state_n = ST_PRE;
                w_pre_n   = '0;
                w_col_n   = '0;
                w_pass_n  = '0;
                w_row_n   = '0;
            end
            ST_PRE: begin
                w_state_n = (r_pre == PRE_W'(PRE_CYCLES - 1)) ? (w_fs_cur ? ST_FS : ST_DS) : ST_PRE;
                w_pre_n   = r_pre + PRE_W'(1);
            end
            ST_DS, ST_FS: begin
                w_row_n  = w_last_row ? '0 : r_row + ROW_W'(1);
                w_pass_n = !w_last_row ? r_pass : w_last_pass ? 2'd0 : r_pass + 2'd1;
                if (w_last_row && w_last_pass) begin
                    w_col_n   = w_last_col ? r_col : w_col_inc;
                    w_state_n = w_last_col ? ST_DONE : w_fs_nxt ? ST_FS : ST_DS;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_abort) begin
            r_state               <= ST_IDLE;
            r_pre                 <= '0;
            r_col                 <= '0;
            r_pass                <= '0;
            r_row                 <= '0;
            r_col_lo              <= '0;
            r_col_hi              <= '0;
            r_ds_rows             <= '0;
            r_fs_rows             <= '0;
            o_busy                <= 1'b0;
            o_done                <= 1'b0;
            o_row_valid           <= 1'b0;
            o_in_curr_enable      <= 1'b0;
            o_cb_select           <= 1'b1;
            o_change_ref          <= 1'b0;
            o_ref_input_control   <= 1'b0;
            o_abs_control         <= '0;
            o_search_column_count <= '0;
            o_search_row_count    <= '0;
        end else if (i_stall) begin
            o_row_valid <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_pre   <= w_pre_n;
            r_col   <= w_col_n;
            r_pass  <= w_pass_n;
            r_row   <= w_row_n;
            if (r_state == ST_IDLE && i_start) begin
                r_col_lo  <= i_cfg_fs_col_lo;
                r_col_hi  <= i_cfg_fs_col_hi;
                r_ds_rows <= (i_cfg_ds_rows < ROW_W'(DS_MIN_ROWS)) ? ROW_W'(DS_MIN_ROWS) : i_cfg_ds_rows;
                r_fs_rows <= (i_cfg_fs_rows < ROW_W'(FS_MIN_ROWS)) ? ROW_W'(FS_MIN_ROWS) : i_cfg_fs_rows;
            end
            o_busy                <= r_state != ST_IDLE;
            o_done                <= r_state == ST_DONE;
            o_row_valid           <= w_in_row;
            o_in_curr_enable      <= r_state == ST_PRE;
            o_cb_select           <= (r_state == ST_PRE) ? (r_pre < PRE_W'(PRE_CYCLES / 2)) :
                                     w_in_row ? w_dec_cb : 1'b1;
            o_change_ref          <= w_in_row && w_dec_cr;
            o_ref_input_control   <= w_in_row && w_dec_ric;
            o_abs_control         <= w_in_row ? w_dec_abs : 2'd0;
            o_search_column_count <= w_in_row ? r_col : '0;
            o_search_row_count    <= w_in_row ? r_row : '0;
        end
    end
endmodule

// File: tb/tb_pe_sched_ctrl.sv
// tb_pe_sched_ctrl: cycle-by-cycle check of pe_sched_ctrl against a schedule list built from the row rules.
module tb_pe_sched_ctrl;
    localparam int PRE = 64;
    localparam int NC  = 31;
    localparam int CW  = 5;
    localparam int RW  = 7;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          rv;
        logic          ice;
        logic          cb;
        logic          cr;
        logic          ric;
        logic [1:0]    abs;
        logic [CW-1:0] col;
        logic [RW-1:0] row;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          stall = 1'b0;
    logic [RW-1:0] ds_cfg = 7'd38;
    logic [RW-1:0] fs_cfg = 7'd21;
    logic [CW-1:0] lo = 5'd7;
    logic [CW-1:0] hi = 5'd14;
    logic          o_busy, o_done, o_row_valid, o_in_curr_enable, o_cb_select;
    logic          o_change_ref, o_ref_input_control;
    logic [1:0]    o_abs_control;
    logic [CW-1:0] o_search_column_count;
    logic [RW-1:0] o_search_row_count;

    int   checks = 0;
    int   errors = 0;
    rec_t q[$];
    rec_t exp_r;
    rec_t act;
    bit   armed = 0;
    bit   idle_w;
    bit   probe_en = 0;
    int   hits = 0;
    int   occ[32][128];
    bit   dirty = 0;

    pe_sched_ctrl dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_start              (start),
        .i_abort              (abort),
        .i_stall              (stall),
        .i_cfg_ds_rows        (ds_cfg),
        .i_cfg_fs_rows        (fs_cfg),
        .i_cfg_fs_col_lo      (lo),
        .i_cfg_fs_col_hi      (hi),
        .o_busy               (o_busy),
        .o_done               (o_done),
        .o_row_valid          (o_row_valid),
        .o_in_curr_enable     (o_in_curr_enable),
        .o_cb_select          (o_cb_select),
        .o_change_ref         (o_change_ref),
        .o_ref_input_control  (o_ref_input_control),
        .o_abs_control        (o_abs_control),
        .o_search_column_count(o_search_column_count),
        .o_search_row_count   (o_search_row_count)
    );

    always #5 clk = ~clk;

    function automatic rec_t mk(bit busy, bit done, bit rv, bit ice, bit cb, bit cr, bit ric,
                                int abs, int col, int row);
        rec_t x;
        x.busy = busy; x.done = done; x.rv = rv; x.ice = ice; x.cb = cb; x.cr = cr; x.ric = ric;
        x.abs = 2'(abs); x.col = CW'(col); x.row = RW'(row);
        return x;
    endfunction

    function automatic rec_t outs();
        return {o_busy, o_done, o_row_valid, o_in_curr_enable, o_cb_select, o_change_ref,
                o_ref_input_control, o_abs_control, o_search_column_count, o_search_row_count};
    endfunction

    // expected output sequence of one whole schedule, straight from the row rules
    function automatic void build();
        int ds = (int'(ds_cfg) < 13) ? 13 : int'(ds_cfg);
        int fs = (int'(fs_cfg) < 5) ? 5 : int'(fs_cfg);
        for (int i = 0; i < PRE; i++) q.push_back(mk(1, 0, 0, 1, i < PRE / 2, 0, 0, 0, 0, 0));
        for (int c = 0; c < NC; c++) begin
            if (c >= int'(lo) && c <= int'(hi)) begin
                for (int p = 0; p < 4; p++)
                    for (int r = 0; r < fs; r++) q.push_back(mk(1, 0, 1, 0, 0, 1, r < 4, p, c, r));
            end else begin
                for (int p = 0; p < 2; p++)
                    for (int r = 0; r < ds; r++) begin
                        int a;
                        bit cr;
                        if (r < 8) begin a = 2 * p; cr = 1; end
                        else if (r < ds - 4) begin a = (r % 2 == 0) ? 2 * p + 1 : 2 * p; cr = (r % 2 != 0); end
                        else begin a = 2 * p + 1; cr = 1; end
                        q.push_back(mk(1, 0, 1, 0, p == 0, cr, 1, a, c, r));
                    end
            end
        end
        q.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    endfunction

    task automatic chk(input string name, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d t=%0t", name, a, e, $time);
        end
    endtask

    always @(posedge clk) begin
        armed = 1;
        if (!rst_n || abort) begin
            q.delete();
            exp_r = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        end else if (stall) begin
            exp_r.rv = 1'b0;
        end else begin
            idle_w = q.size() == 0;
            exp_r  = idle_w ? mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0) : q.pop_front();
            if (idle_w && start) build();
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            act = outs();
            checks++;
            if (act !== exp_r) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t dut=%h model=%h", $time, act, exp_r);
            end
        end
    end

    // literal pins on specific rows; pass number is the occurrence count of (col,row)
    always @(negedge clk) begin
        if (!o_busy && dirty) begin
            foreach (occ[i, j]) occ[i][j] = 0;
            dirty = 0;
        end
        if (o_row_valid) begin
            int n;
            dirty = 1;
            occ[o_search_column_count][o_search_row_count]++;
            n = occ[o_search_column_count][o_search_row_count];
            if (probe_en && o_search_column_count == 0 && n == 2) begin
                if (o_search_row_count == 8) begin hits++; chk("ds_p1_r8", {o_abs_control, o_change_ref}, 3'b110); end
                if (o_search_row_count == 9) begin hits++; chk("ds_p1_r9", {o_abs_control, o_change_ref}, 3'b101); end
                if (o_search_row_count == 35) begin hits++; chk("ds_p1_r35", {o_abs_control, o_change_ref}, 3'b111); end
            end
            if (probe_en && o_search_column_count == 7 && n == 3) begin
                if (o_search_row_count == 3) begin hits++; chk("fs_p2_r3", {o_abs_control, o_ref_input_control}, 3'b101); end
                if (o_search_row_count == 4) begin hits++; chk("fs_p2_r4", {o_abs_control, o_ref_input_control}, 3'b100); end
            end
        end
    end

    task automatic run(input int stall_col, input bit restart, output int lat, output int gaps, output int holes);
        int  sl = 0;
        bit  stalled = 0;
        @(negedge clk) start = 1;
        @(posedge clk);
        @(negedge clk) start = 0;
        lat = 0; gaps = 0; holes = 0;
        while (!o_done && lat < 4000) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (!o_busy) gaps++;
            if (o_busy && !o_row_valid && !o_in_curr_enable && !o_done) holes++;
            start = restart && lat == 300;
            if (stall_col >= 0 && !stalled && o_row_valid && int'(o_search_column_count) == stall_col) begin
                stalled = 1;
                sl = 5;
            end
            stall = sl > 0;
            if (sl > 0) sl--;
        end
        start = 0;
        stall = 0;
        if (!o_done) $display("FAIL run_timeout got=%0d want=done", lat);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat, gaps, holes, h0;
        bit  seen;
        repeat (3) @(negedge clk);
        chk("reset_cb", o_cb_select, 1);
        chk("reset_busy", o_busy, 0);
        chk("reset_rest", {o_done, o_row_valid, o_in_curr_enable, o_change_ref, o_ref_input_control,
                           o_abs_control, o_search_column_count, o_search_row_count}, 0);
        rst_n = 1;
        probe_en = 1;
        h0 = hits;
        run(-1, 0, lat, gaps, holes);
        probe_en = 0;
        chk("lat_nominal", lat, 64 + 23 * 76 + 8 * 84 + 1);
        chk("busy_gaps", gaps, 0);
        chk("row_bubbles", holes, 0);
        chk("probe_hits", hits - h0, 5);

        run(2, 0, lat, gaps, holes);
        chk("lat_stall", lat, 64 + 23 * 76 + 8 * 84 + 1 + 5);
        chk("stall_rv_low", holes, 5);

        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        for (int i = 0; i < 4000 && !(o_row_valid && o_search_column_count == 10); i++) @(negedge clk);
        chk("abort_reached", o_search_column_count, 10);
        abort = 1;
        @(negedge clk) abort = 0;
        chk("abort_idle", {o_busy, o_cb_select, o_row_valid}, 3'b010);
        seen = 0;
        repeat (2000) begin
            @(negedge clk);
            if (o_done) seen = 1;
        end
        chk("abort_no_done", seen, 0);

        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        for (int i = 0; i < 4000 && !(o_row_valid && o_search_column_count == 8); i++) @(negedge clk);
        chk("fs_col_abs", o_abs_control, 0);
        rst_n = 0;
        @(negedge clk);
        chk("rst_mid_fs", outs(), mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        rst_n = 1;

        ds_cfg = 7'd3; fs_cfg = 7'd2; lo = 5'd5; hi = 5'd3;
        run(-1, 1, lat, gaps, holes);
        chk("lat_ds_clamp", lat, 64 + 31 * 2 * 13 + 1);
        chk("clamp_busy_gaps", gaps, 0);

        ds_cfg = 7'd13; fs_cfg = 7'd4; lo = 5'd0; hi = 5'd30;
        run(-1, 0, lat, gaps, holes);
        chk("lat_all_fs", lat, 64 + 31 * 4 * 5 + 1);
        chk("all_fs_bubbles", holes, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
